mem_stage: RTL

//  Memory stage of the 5-stage pipe; sits directly downstream of execute and feeds writeback.

---
 rtl/mem_stage_if.sv | 40 ++++
 rtl/mem_stage.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// Execute-to-memory pipeline bundle: execute results in, data-memory response in,
// registered memory-stage results, forwarding and stall signals out.
interface mem_stage_if;
  logic        halt;
  logic [31:0] ex_result_1;
  logic [31:0] ex_result_2;
  logic [4:0]  ex_tgt_1;
  logic [4:0]  ex_tgt_2;
  logic [4:0]  ex_opcode;
  logic        ex_bubble;
  logic        ex_halt;
  logic        ex_is_load;
  logic [1:0]  ex_addr_lo;
  logic [31:0] dmem_rdata;
  logic        dmem_rvalid;
  logic [31:0] mem_result_out_1;
  logic [31:0] mem_result_out_2;
  logic [4:0]  mem_tgt_1;
  logic [4:0]  mem_tgt_2;
  logic [4:0]  mem_opcode_out;
  logic        mem_bubble;
  logic        is_load_mem;
  logic        mem_halt_out;
  logic        mem_stall;
  logic        load_err;

  modport master (
    output halt, ex_result_1, ex_result_2, ex_tgt_1, ex_tgt_2, ex_opcode,
           ex_bubble, ex_halt, ex_is_load, ex_addr_lo, dmem_rdata, dmem_rvalid,
    input  mem_result_out_1, mem_result_out_2, mem_tgt_1, mem_tgt_2, mem_opcode_out,
           mem_bubble, is_load_mem, mem_halt_out, mem_stall, load_err
  );

  modport slave (
    input  halt, ex_result_1, ex_result_2, ex_tgt_1, ex_tgt_2, ex_opcode,
           ex_bubble, ex_halt, ex_is_load, ex_addr_lo, dmem_rdata, dmem_rvalid,
    output mem_result_out_1, mem_result_out_2, mem_tgt_1, mem_tgt_2, mem_opcode_out,
           mem_bubble, is_load_mem, mem_halt_out, mem_stall, load_err
  );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: waits for the data-memory load response, aligns/zero-extends it and
// registers the instruction toward writeback; stalls upstream while a load is pending.
//   state   | meaning
//   ST_RUN  | no load outstanding; instructions advance every cycle
//   ST_WAIT | load in MEM waiting for dmem_rvalid; wait_cnt counts cycles waited
module mem_stage #(
  parameter int unsigned MAX_WAIT = 255,
  parameter logic [31:0] ERR_FILL = 32'h0
) (
  input logic       clk,
  input logic       rst_n,
  mem_stage_if.slave bus
);

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  state_t      state, state_d;
  logic [7:0]  wait_cnt, wait_cnt_d;
  logic [1:0]  addr_lo_q;
  logic [31:0] res_1, res_1_d, res_2, res_2_d;
  logic [4:0]  tgt_1, tgt_1_d, tgt_2, tgt_2_d, opcode, opcode_d;
  logic        bubble, bubble_d, is_load, is_load_d, halt_q, halt_d, load_err_q, load_err_d;
  logic        valid_ld, at_limit, stall;
  logic [31:0] ld_data;

  assign valid_ld = bus.ex_is_load && !bus.ex_bubble;
  assign at_limit = (state == ST_WAIT) && (wait_cnt == MAX_W);
  assign stall    = valid_ld && !bus.dmem_rvalid && !at_limit;

  always_comb begin
    ld_data = bus.ex_result_1;
    if (bus.ex_opcode inside {[5'd3:5'd5]}) begin
      ld_data = bus.dmem_rdata;
    end else if (bus.ex_opcode inside {[5'd6:5'd8]}) begin
      ld_data = {16'h0, addr_lo_q[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0]};
    end else if (bus.ex_opcode inside {[5'd9:5'd11]}) begin
      ld_data = {24'h0, bus.dmem_rdata[8*addr_lo_q +: 8]};
    end
  end

  always_comb begin
    logic advance, timeout, insert_bubble;
    state_d       = state;
    wait_cnt_d    = wait_cnt;
    res_1_d       = res_1;
    res_2_d       = res_2;
    tgt_1_d       = tgt_1;
    tgt_2_d       = tgt_2;
    opcode_d      = opcode;
    bubble_d      = bubble;
    is_load_d     = is_load;
    halt_d        = halt_q;
    load_err_d    = 1'b0;
    advance       = 1'b0;
    timeout       = 1'b0;
    insert_bubble = 1'b0;

    case (state)
      ST_RUN: begin
        if (valid_ld && !bus.dmem_rvalid) begin
          state_d       = ST_WAIT;
          wait_cnt_d    = 8'd1;
          insert_bubble = 1'b1;
        end else begin
          advance = 1'b1;
        end
      end
      ST_WAIT: begin
        if (bus.dmem_rvalid) begin
          advance    = 1'b1;
          state_d    = ST_RUN;
          wait_cnt_d = 8'd0;
        end else if (at_limit) begin
          advance    = 1'b1;
          timeout    = 1'b1;
          state_d    = ST_RUN;
          wait_cnt_d = 8'd0;
        end else begin
          wait_cnt_d    = wait_cnt + 8'd1;
          insert_bubble = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase

    // Results are held across inserted bubbles; only the control fields are squashed.
    if (insert_bubble) begin
      bubble_d  = 1'b1;
      tgt_1_d   = 5'd0;
      tgt_2_d   = 5'd0;
      is_load_d = 1'b0;
      halt_d    = 1'b0;
    end

    if (advance) begin
      res_1_d    = timeout ? ERR_FILL : (valid_ld ? ld_data : bus.ex_result_1);
      res_2_d    = bus.ex_result_2;
      tgt_1_d    = bus.ex_tgt_1;
      tgt_2_d    = bus.ex_tgt_2;
      opcode_d   = bus.ex_opcode;
      is_load_d  = bus.ex_is_load;
      bubble_d   = bus.ex_bubble;
      halt_d     = bus.ex_halt && !bus.ex_bubble;
      load_err_d = timeout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      wait_cnt   <= 8'd0;
      addr_lo_q  <= 2'd0;
      res_1      <= 32'h0;
      res_2      <= 32'h0;
      tgt_1      <= 5'd0;
      tgt_2      <= 5'd0;
      opcode     <= 5'd0;
      bubble     <= 1'b1;
      is_load    <= 1'b0;
      halt_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      // The error flag is a strict one-cycle pulse, so it clears even while halted.
      load_err_q <= load_err_d && !bus.halt;
      if (!bus.halt) begin
        state    <= state_d;
        wait_cnt <= wait_cnt_d;
        res_1    <= res_1_d;
        res_2    <= res_2_d;
        tgt_1    <= tgt_1_d;
        tgt_2    <= tgt_2_d;
        opcode   <= opcode_d;
        bubble   <= bubble_d;
        is_load  <= is_load_d;
        halt_q   <= halt_d;
        if (!stall) addr_lo_q <= bus.ex_addr_lo;
      end
    end
  end

  assign bus.mem_result_out_1 = res_1;
  assign bus.mem_result_out_2 = res_2;
  assign bus.mem_tgt_1        = tgt_1;
  assign bus.mem_tgt_2        = tgt_2;
  assign bus.mem_opcode_out   = opcode;
  assign bus.mem_bubble       = bubble;
  assign bus.is_load_mem      = is_load;
  assign bus.mem_halt_out     = halt_q;
  assign bus.mem_stall        = stall;
  assign bus.load_err         = load_err_q;

endmodule
